// File: rtl/alu_arbiter_pkg.sv
// Shared constants for the two-requester ALU arbiter: widths, requester ids, opcodes.
package alu_arbiter_pkg;

    localparam int ARB_DSIZE  = 16;
    localparam int ARB_FLAG_W = 3;

    localparam logic REQ_EX = 1'b0;
    localparam logic REQ_AU = 1'b1;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_SLL = 3'd4,
        OP_SRL = 3'd5,
        OP_SRA = 3'd6,
        OP_RL  = 3'd7
    } alu_op_e;

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// 2-way arbiter, round-robin by default; ALU_ARB_FIXED_PRIO_EN makes req[0] always win.
// Latency: combinational grant. Backpressure: losing requester holds req and retries.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

`ifdef ALU_ARB_FIXED_PRIO_EN
    always_comb begin
        gnt = 2'b00;
        if (req[0])
            gnt = 2'b01;
        else if (req[1])
            gnt = 2'b10;
    end
`else
    // rr_last names the most recently granted requester; reset to 1 so req 0 wins first.
    logic rr_last;

    always_comb begin
        gnt = req;
        if (req == 2'b11)
            gnt = rr_last ? 2'b01 : 2'b10;
    end

    always_ff @(posedge clk) begin
        if (rst)
            rr_last <= 1'b1;
        else if (|gnt)
            rr_last <= gnt[1];
    end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered ALU between EX (req 0) and the address unit (req 1); ALU_ARB_FIXED_PRIO_EN selects fixed priority.
// Latency: grant same cycle, response exactly one cycle later. Backpressure: none on responses; losers retry.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int DSIZE  = ARB_DSIZE,
    parameter int FLAG_W = ARB_FLAG_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic [2:0]        op0,
    input  logic [2:0]        op1,
    input  logic [DSIZE-1:0]  a0,
    input  logic [DSIZE-1:0]  b0,
    input  logic [DSIZE-1:0]  a1,
    input  logic [DSIZE-1:0]  b1,
    input  logic [3:0]        imm0,
    input  logic [3:0]        imm1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rsp_valid0,
    output logic              rsp_valid1,
    output logic [DSIZE-1:0]  rsp_out,
    output logic [FLAG_W-1:0] rsp_flag,
    output logic [DSIZE-1:0]  alu_a,
    output logic [DSIZE-1:0]  alu_b,
    output logic [2:0]        alu_op,
    output logic [3:0]        alu_imm,
    output logic [FLAG_W-1:0] alu_lastflag,
    input  logic [DSIZE-1:0]  alu_out,
    input  logic [FLAG_W-1:0] alu_flag
);

    logic [1:0]        gnt;
    logic              grant_any;
    logic              gid;
    logic              inflight;
    logic              owner;
    logic [FLAG_W-1:0] flag_ctx [2];

    rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .req ({req1, req0}),
        .gnt (gnt)
    );

    assign gnt0      = gnt[0];
    assign gnt1      = gnt[1];
    assign grant_any = |gnt;
    assign gid       = gnt[1] ? REQ_AU : REQ_EX;

    always_comb begin
        alu_op       = OP_AND;
        alu_a        = '0;
        alu_b        = '0;
        alu_imm      = '0;
        alu_lastflag = '0;
        if (gnt[0]) begin
            alu_op  = op0;
            alu_a   = a0;
            alu_b   = b0;
            alu_imm = imm0;
        end else if (gnt[1]) begin
            alu_op  = op1;
            alu_a   = a1;
            alu_b   = b1;
            alu_imm = imm1;
        end
        // Same requester issuing back-to-back: its context is not written yet, so bypass.
        if (grant_any)
            alu_lastflag = (inflight && owner == gid) ? alu_flag : flag_ctx[gid];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight    <= 1'b0;
            owner       <= REQ_EX;
            flag_ctx[0] <= '0;
            flag_ctx[1] <= '0;
        end else begin
            inflight <= grant_any;
            if (grant_any)
                owner <= gid;
            if (inflight)
                flag_ctx[owner] <= alu_flag;
        end
    end

    assign rsp_valid0 = inflight && (owner == REQ_EX);
    assign rsp_valid1 = inflight && (owner == REQ_AU);
    assign rsp_out    = alu_out;
    assign rsp_flag   = alu_flag;

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized and directed bench for alu_arbiter with a stand-in registered ALU and a transaction-level model.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst, req0, req1;
    logic [2:0]  op0, op1;
    logic [15:0] a0, b0, a1, b1;
    logic [3:0]  imm0, imm1;
    logic        gnt0, gnt1, rsp_valid0, rsp_valid1;
    logic [15:0] rsp_out, alu_a, alu_b, alu_out;
    logic [2:0]  rsp_flag, alu_op, alu_lastflag, alu_flag;
    logic [3:0]  alu_imm;
    logic [18:0] alu_q;

    int n_chk = 0;
    int n_bad = 0;

    // model state
    int          m_last = 1;
    bit          m_pv   = 1'b0;
    int          m_pid  = 0;
    logic [15:0] m_pout;
    logic [2:0]  m_pflag;
    logic [2:0]  ctx [2];

    logic        seen_g0, seen_v0, seen_v1;
    logic [15:0] seen_out;
    logic [2:0]  seen_flag;
    logic [3:0]  gpat;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .op0(op0), .op1(op1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1), .imm0(imm0), .imm1(imm1),
        .gnt0(gnt0), .gnt1(gnt1), .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1),
        .rsp_out(rsp_out), .rsp_flag(rsp_flag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_imm(alu_imm),
        .alu_lastflag(alu_lastflag), .alu_out(alu_out), .alu_flag(alu_flag)
    );

    // ALU behaviour: n is the true sign (sign xor overflow); non-arithmetic ops keep lastFlag.
    function automatic logic [18:0] alu_f(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                          input logic [3:0] imm, input logic [2:0] lf);
        logic [15:0] r;
        logic [2:0]  f;
        logic        v;
        logic [31:0] w;
        r = 16'h0;
        f = lf;
        v = 1'b0;
        w = {a, a} << imm;
        case (op)
            OP_ADD: begin
                r = a + b;
                v = (a[15] == b[15]) && (r[15] != a[15]);
                f = {r[15] ^ v, v, r == 16'h0};
            end
            OP_SUB: begin
                r = a - b;
                v = (a[15] != b[15]) && (r[15] != a[15]);
                f = {r[15] ^ v, v, r == 16'h0};
            end
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_SLL:  r = a << imm;
            OP_SRL:  r = a >> imm;
            OP_SRA:  r = $signed(a) >>> imm;
            OP_RL:   r = w[31:16];
            default: r = 16'h0;
        endcase
        return {f, r};
    endfunction

    always @(posedge clk) alu_q <= alu_f(alu_op, alu_a, alu_b, alu_imm, alu_lastflag);
    assign alu_out  = alu_q[15:0];
    assign alu_flag = alu_q[18:16];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic set0(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b, input logic [3:0] imm);
        op0 = op; a0 = a; b0 = b; imm0 = imm;
    endtask

    task automatic set1(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b, input logic [3:0] imm);
        op1 = op; a1 = a; b1 = b; imm1 = imm;
    endtask

    // One clock: check outputs at the falling edge, then advance the model at the rising edge.
    task automatic tick();
        logic        eg0, eg1;
        logic [18:0] res;
        int          id;
        @(negedge clk);
        if (req0 && req1) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            eg0 = 1'b1;
`else
            eg0 = (m_last == 1);
`endif
            eg1 = !eg0;
        end else begin
            eg0 = req0;
            eg1 = req1;
        end
        chk("gnt0", gnt0, eg0);
        chk("gnt1", gnt1, eg1);
        chk("rsp_valid0", rsp_valid0, m_pv && m_pid == 0);
        chk("rsp_valid1", rsp_valid1, m_pv && m_pid == 1);
        if (m_pv) begin
            chk("rsp_out", rsp_out, m_pout);
            chk("rsp_flag", rsp_flag, m_pflag);
        end
        if (!eg0 && !eg1)
            chk("idle_steer", {alu_a, alu_b, alu_op, alu_imm, alu_lastflag},
                {16'h0, 16'h0, 3'(OP_AND), 4'h0, 3'b000});
        seen_g0   = gnt0;
        seen_v0   = rsp_valid0;
        seen_v1   = rsp_valid1;
        seen_out  = rsp_out;
        seen_flag = rsp_flag;
        @(posedge clk);
        if (rst) begin
            m_last = 1; m_pv = 1'b0; ctx[0] = 3'b000; ctx[1] = 3'b000;
        end else if (eg0 || eg1) begin
            id  = eg1 ? 1 : 0;
            res = eg1 ? alu_f(op1, a1, b1, imm1, ctx[1]) : alu_f(op0, a0, b0, imm0, ctx[0]);
            ctx[id] = res[18:16];
            m_pv = 1'b1; m_pid = id; m_pout = res[15:0]; m_pflag = res[18:16]; m_last = id;
        end else begin
            m_pv = 1'b0;
        end
        #1;
    endtask

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 4))
            0: return 16'h7FFF;
            1: return 16'h8000;
            2: return 16'h0000;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        set0(OP_AND, 0, 0, 0); set1(OP_AND, 0, 0, 0);
        ctx[0] = 3'b000; ctx[1] = 3'b000;
        tick(); tick();
        rst = 1'b0;

        // lone request
        set0(OP_ADD, 16'h0003, 16'h0004, 0); req0 = 1'b1; tick();
        chk("lone_gnt0", seen_g0, 1'b1);
        req0 = 1'b0; tick();
        chk("lone_v0", seen_v0, 1'b1);
        chk("lone_v1", seen_v1, 1'b0);
        chk("lone_out", seen_out, 16'h0007);
        chk("lone_flag", seen_flag, 3'b000);

        // conflict after reset
        rst = 1'b1; tick(); rst = 1'b0;
        set0(OP_ADD, 16'd1, 16'd2, 0); set1(OP_ADD, 16'd10, 16'd20, 0);
        req0 = 1'b1; req1 = 1'b1; gpat = 4'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            gpat = {gpat[2:0], seen_g0};
        end
        req0 = 1'b0; req1 = 1'b0; tick();
`ifdef ALU_ARB_FIXED_PRIO_EN
        chk("conflict_pattern", gpat, 4'b1111);
`else
        chk("conflict_pattern", gpat, 4'b1010);
`endif

        // overflow then zero flags on requester 1
        set1(OP_ADD, 16'h7FFF, 16'h0001, 0); req1 = 1'b1; tick();
        set1(OP_SUB, 16'h0005, 16'h0005, 0); tick();
        chk("ovf_out", seen_out, 16'h8000);
        chk("ovf_flag", seen_flag, 3'b010);
        req1 = 1'b0; tick();
        chk("sub_out", seen_out, 16'h0000);
        chk("sub_flag", seen_flag, 3'b001);

        // per-requester flag contexts
        set0(OP_SUB, 16'h0005, 16'h0005, 0); req0 = 1'b1; tick();
        req0 = 1'b0; set1(OP_ADD, 16'h7FFF, 16'h0001, 0); req1 = 1'b1; tick();
        req1 = 1'b0; set0(OP_SLL, 16'h0001, 16'h0000, 4'd2); req0 = 1'b1; tick();
        req0 = 1'b0; set1(OP_OR, 16'h0003, 16'h0004, 0); req1 = 1'b1; tick();
        chk("iso_sll_out", seen_out, 16'h0004);
        chk("iso_sll_flag", seen_flag, 3'b001);
        req1 = 1'b0; tick();
        chk("iso_or_out", seen_out, 16'h0007);
        chk("iso_or_flag", seen_flag, 3'b010);

        // back-to-back issue relies on flag forwarding
        set0(OP_ADD, 16'h0003, 16'h0004, 0); req0 = 1'b1; tick();
        set0(OP_SUB, 16'h0005, 16'h0005, 0); tick();
        set0(OP_AND, 16'hF0F0, 16'h0FF0, 0); tick();
        req0 = 1'b0; tick();
        chk("fwd_out", seen_out, 16'h00F0);
        chk("fwd_flag", seen_flag, 3'b001);

        // reset while an op is in flight
        set0(OP_ADD, 16'h7FFF, 16'h0001, 0); req0 = 1'b1; rst = 1'b1; tick();
        rst = 1'b0; req0 = 1'b0; tick();
        chk("mid_rst_v0", seen_v0, 1'b0);
        chk("mid_rst_v1", seen_v1, 1'b0);
        set0(OP_AND, 16'hFFFF, 16'h1234, 0); req0 = 1'b1; tick();
        req0 = 1'b0; set1(OP_AND, 16'hFFFF, 16'h4321, 0); req1 = 1'b1; tick();
        chk("ctx0_cleared", seen_flag, 3'b000);
        req1 = 1'b0; tick();
        chk("ctx1_cleared", seen_flag, 3'b000);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            rst  = ($urandom_range(0, 49) == 0);
            req0 = 1'($urandom_range(0, 1));
            req1 = 1'($urandom_range(0, 1));
            set0(3'($urandom), pick(), pick(), 4'($urandom));
            set1(3'($urandom), pick(), pick(), 4'($urandom));
            tick();
        end
        rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
        tick(); tick();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
